lfsr_prbs_gen_multi: RTL

Runtime-selectable PRBS pattern generator: PRBS7/9/15/23/31 chosen per seed load rather than fixed at elaboration. Fibonacci LFSR produces DATA_WIDTH bits per generated word. Output is a registered valid/ready stream with backpressure, plus run-time seeding and single-bit error injection. Feeds serdes/link test datapaths; pairs with the PRBS checkers.

---
 rtl/lfsr_prbs_gen_multi.sv | 79 +++++++
 1 files changed

// File: rtl/lfsr_prbs_gen_multi.sv
// lfsr_prbs_gen_multi: runtime-selectable PRBS7/9/15/23/31 word generator with valid/ready output.
// Optional bit-0 error injection is built only when PRBS_GEN_ERR_INJECT_EN is defined.
module lfsr_prbs_gen_multi #(
  parameter int DATA_WIDTH   = 64,
  parameter int DEFAULT_MODE = 4,
  parameter int REVERSE      = 0,
  parameter int INVERT       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  seed_load,
  input  logic [2:0]            mode,
  input  logic [30:0]           seed,
  input  logic                  err_inject,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  err_pending
);
  localparam logic [2:0] DEF_MODE = DEFAULT_MODE > 4 ? 3'd4 : 3'(DEFAULT_MODE);
  localparam logic INV = INVERT != 0;
  function automatic logic [30:0] mask_of(input logic [2:0] md);
    return md == 3'd0 ? 31'h7f : md == 3'd1 ? 31'h1ff : md == 3'd2 ? 31'h7fff :
           md == 3'd3 ? 31'h7fffff : 31'h7fffffff;
  endfunction
  function automatic logic tap(input logic [30:0] s, input logic [2:0] md);
    return md == 3'd0 ? s[6] ^ s[5] : md == 3'd1 ? s[8] ^ s[4] : md == 3'd2 ? s[14] ^ s[13] :
           md == 3'd3 ? s[22] ^ s[17] : s[30] ^ s[27];
  endfunction
  logic [2:0]            mode_q, mode_in;
  logic [30:0]           state_q, state_nxt, seed_m, seed_ld;
  logic [DATA_WIDTH-1:0] word_nxt;
  logic                  gen, b, err_hit;
  assign gen     = enable && (!m_valid || m_ready) && !seed_load;
  assign mode_in = mode > 3'd4 ? 3'd4 : mode;
  assign seed_m  = seed & mask_of(mode_in);
  assign seed_ld = seed_m == '0 ? mask_of(mode_in) : seed_m;
  // Unroll DATA_WIDTH Fibonacci steps; the first bit lands in the MSB unless REVERSE.
  always_comb begin
    state_nxt = state_q;
    word_nxt  = '0;
    b         = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      b = tap(state_nxt, mode_q);
      state_nxt = {state_nxt[29:0], b} & mask_of(mode_q);
      word_nxt[REVERSE != 0 ? i : DATA_WIDTH - 1 - i] = b ^ INV;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= DEF_MODE;
      state_q <= mask_of(DEF_MODE);
      m_valid <= 1'b0;
      m_data  <= '0;
    end else begin
      if (seed_load) begin
        mode_q  <= mode_in;
        state_q <= seed_ld;
      end else if (gen) state_q <= state_nxt;
      if (gen) begin
        m_data  <= word_nxt ^ DATA_WIDTH'(err_hit);
        m_valid <= 1'b1;
      end else if (m_ready) m_valid <= 1'b0;
    end
  end
`ifdef PRBS_GEN_ERR_INJECT_EN
  assign err_hit = err_pending || err_inject;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_pending <= 1'b0;
    else err_pending <= gen ? 1'b0 : err_hit;
  end
`else
  logic unused_err;
  assign unused_err  = err_inject;
  assign err_hit     = 1'b0;
  assign err_pending = 1'b0;
`endif
endmodule
